// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int         PAT_W_DEF   = 4;
  localparam int         REP_W_DEF   = 8;
  localparam int         GAP_W_DEF   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-load, serial-out shift register, MSB first; zeros fill from the LSB so msb
// reads 0 once every loaded bit has been shifted out.
module seq_piso_shift import seq_gen_pkg::*; #(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [PAT_W-1:0] d,
  output logic             msb,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);

  logic [PAT_W-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;

  // r_cnt = number of bits still to follow the one currently at msb
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_sh  <= d;
      r_cnt <= CNT_W'(PAT_W - 1);
    end else if (shift_en) begin
      r_sh  <= {r_sh[PAT_W-2:0], 1'b0};
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign msb   = r_sh[PAT_W-1];
  assign empty = (r_cnt == '0);
  assign cnt   = r_cnt;

endmodule

// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: repeats a latched pattern MSB first with idle gaps between
// repetitions; every output is a flop updated from the next-state decision.
module seq_pattern_generator import seq_gen_pkg::*; #(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [REP_W-1:0] rep_count,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(PAT_W);

  state_e           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [REP_W-1:0] r_rep, w_rep_nxt;
  logic [GAP_W-1:0] r_gap, r_gap_cnt, w_gap_cnt_nxt;
  logic             r_vld, r_last, r_done, r_busy, r_ready;
  logic             w_accept, w_load, w_shift, w_clr, w_last_nxt;
  logic             w_msb, w_empty;
  logic [CNT_W-1:0] w_cnt;
  logic [PAT_W-1:0] w_load_val;

  assign w_load_val = (r_state == IDLE) ? pattern_in : r_pat;

  seq_piso_shift #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_piso (
    .clk      (clk),
    .clr      (rst || w_clr),
    .load     (w_load),
    .shift_en (w_shift),
    .d        (w_load_val),
    .msb      (w_msb),
    .empty    (w_empty),
    .cnt      (w_cnt)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_rep_nxt     = r_rep;
    w_gap_cnt_nxt = r_gap_cnt;
    w_accept      = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    w_clr         = 1'b0;
    w_last_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_valid && !abort) begin
          w_accept  = 1'b1;
          w_rep_nxt = rep_count;
          if (rep_count != '0) begin
            w_state_nxt = SHIFT;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        if (!w_empty) begin
          w_shift    = 1'b1;
          w_last_nxt = (w_cnt == CNT_W'(1)) && (r_rep == REP_W'(1));
        end else begin
          // Shifting the final bit out leaves the register all-zero, so out idles at 0
          w_rep_nxt = r_rep - 1'b1;
          if (r_rep > REP_W'(1)) begin
            if (r_gap != '0) begin
              w_state_nxt   = GAP;
              w_shift       = 1'b1;
              w_gap_cnt_nxt = r_gap;
            end else begin
              w_load = 1'b1;
            end
          end else begin
            w_state_nxt = DONE;
            w_shift     = 1'b1;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(1)) begin
          w_state_nxt   = SHIFT;
          w_load        = 1'b1;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort && (r_state != IDLE)) begin
      w_state_nxt   = IDLE;
      w_clr         = 1'b1;
      w_load        = 1'b0;
      w_shift       = 1'b0;
      w_last_nxt    = 1'b0;
      w_rep_nxt     = '0;
      w_gap_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rep     <= '0;
      r_gap_cnt <= '0;
      r_gap     <= '0;
      r_pat     <= '0;
      r_vld     <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_rep     <= w_rep_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      if (w_accept) begin
        r_pat <= pattern_in;
        r_gap <= gap_len;
      end
      r_vld   <= (w_state_nxt == SHIFT);
      r_last  <= w_last_nxt;
      r_done  <= (w_state_nxt == DONE);
      r_busy  <= (w_state_nxt != IDLE);
      r_ready <= (w_state_nxt == IDLE);
    end
  end

  assign out         = w_msb;
  assign out_valid   = r_vld;
  assign out_last    = r_last;
  assign done        = r_done;
  assign busy        = r_busy;
  assign start_ready = r_ready;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Directed bench for seq_pattern_generator: per-cycle checks against a bit queue built
// from each burst's pattern/repeat/gap settings.
module tb_seq_pattern_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] pattern_in;
  logic [7:0] rep_count;
  logic [3:0] gap_len;
  logic       abort;
  logic       out;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  seq_pattern_generator #(.PAT_W(4), .REP_W(8), .GAP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pattern_in  (pattern_in),
    .rep_count   (rep_count),
    .gap_len     (gap_len),
    .abort       (abort),
    .out         (out),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out"},   32'(out), 0);
    chk({tag, ".vld"},   32'(out_valid), 0);
    chk({tag, ".last"},  32'(out_last), 0);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".ready"}, 32'(start_ready), 1);
  endtask

  // Each queue entry is {out_valid, out, out_last} for one cycle after acceptance.
  task automatic burst(input string tag, input logic [3:0] pat, input int rep,
                       input int gap, input int exp_vcnt, input bit hold);
    logic [2:0] q[$];
    int vcnt = 0;
    for (int r = 0; r < rep; r++) begin
      for (int b = 3; b >= 0; b--) q.push_back({1'b1, pat[b], (r == rep - 1) && (b == 0)});
      if (r < rep - 1) for (int g = 0; g < gap; g++) q.push_back(3'b000);
    end
    pattern_in  = pat;
    rep_count   = 8'(rep);
    gap_len     = 4'(gap);
    start_valid = 1'b1;
    cyc();
    if (!hold) start_valid = 1'b0;
    foreach (q[i]) begin
      chk({tag, ".vld"},   32'(out_valid), 32'(q[i][2]));
      chk({tag, ".out"},   32'(out), 32'(q[i][1]));
      chk({tag, ".last"},  32'(out_last), 32'(q[i][0]));
      chk({tag, ".busy"},  32'(busy), 1);
      chk({tag, ".ready"}, 32'(start_ready), 0);
      chk({tag, ".done"},  32'(done), 0);
      if (out_valid === 1'b1) vcnt++;
      cyc();
    end
    chk({tag, ".done_pulse"}, 32'(done), 1);
    chk({tag, ".done_busy"},  32'(busy), 1);
    chk({tag, ".done_vld"},   32'(out_valid), 0);
    chk({tag, ".done_out"},   32'(out), 0);
    cyc();
    chk_idle({tag, ".after"});
    chk({tag, ".vcnt"}, 32'(vcnt), 32'(exp_vcnt));
    if (hold) begin
      start_valid = 1'b0;
      cyc();
      chk({tag, ".no_second_busy"}, 32'(busy), 0);
      chk({tag, ".no_second_vld"},  32'(out_valid), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0;
    pattern_in = 4'b0; rep_count = 8'd0; gap_len = 4'd0;
    cyc();
    cyc();
    chk_idle("reset");
    rst = 1'b0;
    cyc();
    chk_idle("post_reset");

    // 1: single repetition, bits in k+1..k+4, done k+5, ready k+6
    burst("t1_rep1", 4'b1011, 1, 0, 4, 1'b0);
    // 2: three reps with 2-cycle gaps, 16 cycles, 12 valid bits
    burst("t2_rep3_gap2", 4'b1011, 3, 2, 12, 1'b0);
    // 3: back-to-back repetitions, 8 consecutive valid bits
    burst("t3_rep2_gap0", 4'b1011, 2, 0, 8, 1'b0);
    // 4: zero repetitions, done in k+1
    burst("t4_rep0", 4'b1011, 0, 3, 0, 1'b0);
    burst("t_pat0110_gap1", 4'b0110, 2, 1, 8, 1'b0);
    burst("t_gapmax", 4'b1100, 2, 15, 8, 1'b0);
    burst("t_repmax", 4'b1001, 255, 0, 1020, 1'b0);

    // 5a: abort on the third bit
    pattern_in = 4'b1011; rep_count = 8'd2; gap_len = 4'd1; start_valid = 1'b1;
    cyc();
    start_valid = 1'b0;
    chk("abort.bit1", 32'(out), 1);
    cyc();
    chk("abort.bit2", 32'(out), 0);
    cyc();
    chk("abort.bit3", 32'(out), 1);
    chk("abort.bit3_vld", 32'(out_valid), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_idle("abort.next");
    cyc();
    chk_idle("abort.later");

    // abort together with start in IDLE: not accepted
    start_valid = 1'b1; abort = 1'b1;
    cyc();
    start_valid = 1'b0; abort = 1'b0;
    chk_idle("abort_start_idle");
    cyc();
    chk_idle("abort_start_idle2");

    // 5b: start_valid held through a burst runs exactly one burst
    burst("t5_hold", 4'b1011, 1, 0, 4, 1'b1);

    // 6: reset in the middle of a gap
    pattern_in = 4'b1011; rep_count = 8'd3; gap_len = 4'd2; start_valid = 1'b1;
    cyc();
    start_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("rst_gap.in_gap_vld",  32'(out_valid), 0);
    chk("rst_gap.in_gap_busy", 32'(busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_idle("rst_gap.next");
    burst("t6_after_rst", 4'b1011, 2, 1, 8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
